// File: rtl/ahb_arb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_arb_pkg
//   Shared types and helpers for the parametrised AHB arbiter.
//   - htrans_e / hresp_e : AHB transfer-type and response encodings
//   - MAX_MASTERS        : upper bound on N_MASTERS
//   - onehot2idx         : one-hot vector (up to MAX_MASTERS) -> index
//   - idx2onehot         : index -> one-hot vector (MAX_MASTERS wide)
// ---------------------------------------------------------------------------
package ahb_arb_pkg;

  localparam int MAX_MASTERS = 16;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_e;

  // Index of the set bit; callers guarantee the vector is one-hot.
  function automatic int onehot2idx(input logic [MAX_MASTERS-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) r = i;
    end
    return r;
  endfunction

  function automatic logic [MAX_MASTERS-1:0] idx2onehot(input int idx);
    logic [MAX_MASTERS-1:0] r;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      r[i] = (i == idx);
    end
    return r;
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// ---------------------------------------------------------------------------
// ahb_rr_picker
//   Combinational request picker shared by both arbitration policies.
//   RR_MODE=0: lowest set index of req wins; ptr is ignored.
//   RR_MODE=1: first set index scanning ptr+1, ptr+2, ... with wrap; ptr
//              itself is scanned last.
//   Ports:
//     req   in  N_MASTERS  eligible requests
//     ptr   in  log2(N)    round-robin pointer (last serviced master)
//     pick  out N_MASTERS  one-hot winner (zero when valid=0)
//     valid out 1          at least one request present
// ---------------------------------------------------------------------------
module ahb_rr_picker #(
  parameter int N_MASTERS = 16,
  parameter int RR_MODE   = 1
) (
  input  logic [N_MASTERS-1:0]         req,
  input  logic [$clog2(N_MASTERS)-1:0] ptr,
  output logic [N_MASTERS-1:0]         pick,
  output logic                         valid
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise synthesis infers a latch.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    // First pass: indices above ptr (round robin) or all indices (fixed).
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!valid && req[i] && (RR_MODE == 0 || i > int'(ptr))) begin
        pick[i] = 1'b1;
        valid   = 1'b1;
      end
    end
    // Second pass wraps around to 0..ptr.
    if (RR_MODE != 0) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (!valid && req[i] && i <= int'(ptr)) begin
          pick[i] = 1'b1;
          valid   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter_param.sv
// ---------------------------------------------------------------------------
// ahb_arbiter_param
//   N-master AHB-Lite arbiter: fixed-priority or round-robin policy,
//   locked-transfer hold, SPLIT masking/unmasking and a default master.
//   Ports:
//     HCLK       in  1          bus clock
//     HRESET     in  1          synchronous active-high reset
//     HBUSREQx   in  N_MASTERS  per-master bus request
//     HLOCKx     in  N_MASTERS  per-master locked-transfer request
//     HSPLITx    in  N_MASTERS  split release, bit i unmasks master i
//     HREADY     in  1          current transfer completing
//     HRESP      in  2          slave response
//     HGRANTx    out N_MASTERS  one-hot grant (registered)
//     HMASTER    out MW         address-phase owner (registered)
//     HMASTLOCK  out 1          address phase is locked (registered)
// ---------------------------------------------------------------------------
module ahb_arbiter_param
  import ahb_arb_pkg::*;
#(
  parameter int N_MASTERS      = 16,
  parameter int MW             = $clog2(N_MASTERS),
  parameter int RR_MODE        = 1,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [N_MASTERS-1:0] HBUSREQx,
  input  logic [N_MASTERS-1:0] HLOCKx,
  input  logic [N_MASTERS-1:0] HSPLITx,
  input  logic                 HREADY,
  input  logic [1:0]           HRESP,
  output logic [N_MASTERS-1:0] HGRANTx,
  output logic [MW-1:0]        HMASTER,
  output logic                 HMASTLOCK
);

  localparam logic [N_MASTERS-1:0] DEFAULT_OH = N_MASTERS'(idx2onehot(DEFAULT_MASTER));

  logic [N_MASTERS-1:0] split_mask;
  logic [N_MASTERS-1:0] split_set;
  logic [N_MASTERS-1:0] eff_mask;
  logic [N_MASTERS-1:0] elig;
  logic [N_MASTERS-1:0] master_oh;
  logic [N_MASTERS-1:0] pick;
  logic [N_MASTERS-1:0] next_grant;
  logic [MW-1:0]        rr_ptr;
  logic [MW-1:0]        grant_idx;
  logic [MW-1:0]        arb_ptr;
  logic                 granted_by_req;
  logic                 next_by_req;
  logic                 split_hit;
  logic                 lock_hold;
  logic                 force_off;
  logic                 grant_update;
  logic                 pick_valid;

  always_comb begin
    grant_idx = MW'(onehot2idx(MAX_MASTERS'(HGRANTx)));
    master_oh = N_MASTERS'(idx2onehot(int'(HMASTER)));

    // First cycle of a SPLIT response masks the current owner this edge.
    split_hit = (HRESP == HRESP_SPLIT) && !HREADY;
    split_set = split_hit ? master_oh : '0;
    eff_mask  = split_mask | split_set;
    elig      = HBUSREQx & ~eff_mask;

    // A master granted through a request is the one being serviced now, so
    // the scan starts after it straight away rather than after the pointer
    // that only catches up at the handover; this keeps grants from repeating.
    arb_ptr = granted_by_req ? grant_idx : rr_ptr;

    lock_hold    = HMASTLOCK && |(HLOCKx & master_oh) && !(|(eff_mask & master_oh));
    force_off    = split_hit && |(HGRANTx & master_oh);
    grant_update = HREADY || force_off;
  end

  ahb_rr_picker #(
    .N_MASTERS (N_MASTERS),
    .RR_MODE   (RR_MODE)
  ) u_picker (
    .req   (elig),
    .ptr   (arb_ptr),
    .pick  (pick),
    .valid (pick_valid)
  );

  always_comb begin
    next_grant  = HGRANTx;
    next_by_req = granted_by_req;
    if (!lock_hold) begin
      if (pick_valid) begin
        next_grant  = pick;
        next_by_req = 1'b1;
      end else begin
        // Default master is granted even when split-masked.
        next_grant  = DEFAULT_OH;
        next_by_req = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HGRANTx        <= DEFAULT_OH;
      HMASTER        <= MW'(DEFAULT_MASTER);
      HMASTLOCK      <= 1'b0;
      split_mask     <= '0;
      rr_ptr         <= MW'(DEFAULT_MASTER);
      granted_by_req <= 1'b0;
    end else begin
      // Clear after set: a simultaneous release wins over a new SPLIT.
      split_mask <= (split_mask | split_set) & ~HSPLITx;
      if (grant_update) begin
        HGRANTx        <= next_grant;
        granted_by_req <= next_by_req;
      end
      if (HREADY) begin
        HMASTER   <= grant_idx;
        HMASTLOCK <= |(HLOCKx & HGRANTx);
        if (granted_by_req) rr_ptr <= grant_idx;
      end
    end
  end

endmodule
